// File: rtl/mux_4_1_rr_ctrl_if.sv
// Bundle between the round-robin capture controller, the 4:1 mux and the downstream consumer.
// master = controller side, slave = environment (sources, mux, sink).
interface mux_4_1_rr_ctrl_if #(
  parameter int unsigned W = 4
);
  logic [3:0]   req;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [W-1:0] mux_y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_chan;

  modport master (
    input  req, mux_y, out_ready,
    output gnt, sel, out_valid, out_data, out_chan
  );

  modport slave (
    output req, mux_y, out_ready,
    input  gnt, sel, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/mux_4_1_rr_ctrl.sv
// Round-robin arbiter driving the mux_4_1 select, with a one-entry valid/ready capture register
// for the selected word.
module mux_4_1_rr_ctrl #(
  parameter int unsigned W = 4
) (
  input logic               clk,
  input logic               rst,
  mux_4_1_rr_ctrl_if.master bus
);
  logic [1:0]   ptr;
  logic [1:0]   winner;
  logic         found;
  logic         space;
  logic [1:0]   idx;
  logic [3:0]   gnt_c;
  logic         valid_q;
  logic [W-1:0] data_q;
  logic [1:0]   chan_q;

  // Search ptr+1 .. ptr+4 (== ptr); with no request winner stays at ptr so sel is quiet on idle.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign space = !valid_q || bus.out_ready;

  // Reset also suppresses the grant so no source believes it was accepted on a reset edge.
  always_comb begin
    gnt_c = '0;
    if (!rst && found && space) gnt_c[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      ptr     <= 2'd3;
    end else if (gnt_c != '0) begin
      valid_q <= 1'b1;
      data_q  <= bus.mux_y;
      chan_q  <= winner;
      ptr     <= winner;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.sel       = winner;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
endmodule

// File: doc/mux_4_1_rr_ctrl.md
Name: mux_4_1_rr_ctrl

Overview:
- Control and capture stage that wraps the 4-bit 4:1 mux (mux_4_1). It arbitrates four requesting sources round-robin and drives the mux select. It registers the selected mux output into a one-entry output register with a valid/ready handshake.
- Upstream sources present data directly on the mux d0..d3. This block sees only the request lines and the mux result y.

Parameters:
- W, 4, data width of mux_y / out_data; must match the mux data width.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-source request; bit i means d_i on the mux is valid.
- gnt  output 4  one-hot grant; gnt[i] means d_i was accepted this cycle. Combinational.
- sel  output 2  select to mux_4_1. Combinational.
- mux_y  input  W  mux_4_1 output y.
- out_valid  output 1  out_data/out_chan hold a captured word.
- out_ready  input  1  downstream accepts the word this cycle.
- out_data  output W  captured mux_y.
- out_chan  output 2  index of the source that out_data came from.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_chan=0.
  - Last-grant pointer = 3, so source 0 has highest priority first.
  - rst overrides all other activity in that cycle, including a pending accept or drain. A word held in the output register is discarded.
- Space condition: space = !out_valid || out_ready, combinational.
- Arbitration is combinational:
  - Candidates are searched in order ptr+1, ptr+2, ptr+3, ptr, modulo 4. The winner is the first i with req[i]=1.
  - sel = winner when any req is set. Otherwise sel = ptr, the last granted source, so the mux does not toggle on idle.
- Grant: gnt[winner]=1 only when any req is set and space=1; otherwise gnt=0. At most one gnt bit is ever high.
- Accept edge (gnt!=0):
  - out_data <= mux_y, out_chan <= sel, out_valid <= 1.
  - ptr <= sel.
- Drain edge (out_valid && out_ready && gnt==0): out_valid <= 0. out_data and out_chan hold their values.
- Simultaneous drain and accept in the same cycle: the new word replaces the old one, out_valid stays 1. Sustained throughput is one word per cycle.
- Stall (out_valid && !out_ready):
  - gnt=0, and out_data, out_chan and ptr hold.
  - sel still follows the arbitration rule, so it may change. Nothing is captured.
- Latency: a request granted in cycle N appears on out_data/out_valid in cycle N+1.
- Source rule: a source holds req and its d_i stable until it sees gnt[i]. Dropping req without a grant is legal; the request is simply not considered.
- Fairness: with all four req bits held high and out_ready=1, grants rotate 0,1,2,3,0,… with no source starving. Worst-case wait is 3 grants.
- mux_y is sampled only on accept edges. No combinational path runs from mux_y to any output.
- Combinational paths: req and out_ready reach gnt; req reaches sel.

Test Plan:
- Reset behaviour: hold rst 2 cycles with req=4'b1111 and out_ready=1 -> gnt=0, out_valid=0, out_data=0, out_chan=0. On the first cycle after reset, gnt=4'b0001 and sel=0.
- Round robin: req=4'b1111 with d0..d3=4'hA,4'hB,4'hC,4'hD and out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 and out_data sequence A,B,C,D,A,B,C,D. out_valid stays 1 continuously from cycle 2.
- Sparse requests: req=4'b1010 held, out_ready=1 -> grants alternate 1,3,1,3. With req=0, sel holds the last grant (3) and gnt=0.
- Backpressure: capture chan 2 with d2=4'h5, then hold out_ready=0 for 4 cycles while req=4'b1111 -> gnt=0, out_data=5 and out_chan=2 stable. When out_ready is released, the next grant goes to source 3.
- Simultaneous drain and accept: out_valid=1, out_ready=1 and req=4'b0001 in the same cycle -> the new word (d0) is captured next cycle and out_valid never drops.
- Mid-operation reset: assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, and the next grant goes to source 0 regardless of the previous pointer.
